// File: rtl/aes_sched_pkg.sv
// Shared crypto definitions for the AES scheduling slice: widths, default core
// latency, scheduler state encoding and the key register address.
package aes_sched_pkg;

  localparam int unsigned AES_BLOCK_W     = 128;
  localparam int unsigned AES_KEY_W       = 128;
  localparam int unsigned KEY_WORD_W      = 32;
  localparam int unsigned AES_LATENCY_DEF = 21;
  localparam int unsigned IN_FLIGHT_W     = 5;

  // Software-visible key word register
  localparam logic [11:0] KEY_REG_ADDR = 12'h040;

  typedef enum logic [1:0] {
    SCHED_RUN   = 2'd0,
    SCHED_DRAIN = 2'd1,
    SCHED_LOAD  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/aes_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr_i+1 upward (mod NUM_REQ)
// and returns a one-hot grant for the first active request, or zero.
module aes_sched_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic found;

  // Outer loop walks priority order, inner loop maps it to a fixed index
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && req_i[j] && (((32'(ptr_i) + k) % NUM_REQ) == j)) begin
          gnt_o[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/aes_sched.sv
// Shares one pipelined aes_128 core between NUM_REQ requesters, tags results
// with the requester ID, and sequences key changes so no block sees a mixed key.
module aes_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned AES_LATENCY = AES_LATENCY_DEF,
  parameter int unsigned ID_WIDTH    = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         key_wr,
  input  logic [KEY_WORD_W-1:0]        key_in,
  output logic [AES_BLOCK_W-1:0]       aes_state,
  output logic [AES_KEY_W-1:0]         aes_key,
  input  logic [AES_BLOCK_W-1:0]       aes_out,
  output logic                         rsp_valid,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic [AES_BLOCK_W-1:0]       rsp_data,
  output logic [IN_FLIGHT_W-1:0]       in_flight,
  output logic                         key_busy
);

  sched_state_e               state_q, state_d;
  logic [KEY_WORD_W-1:0]      key_q, key_d;
  logic [KEY_WORD_W-1:0]      key_pend_q, key_pend_d;
  logic [ID_WIDTH-1:0]        rr_q, rr_d;
  logic [IN_FLIGHT_W-1:0]     in_flight_q, in_flight_d;
  logic                       key_busy_q, key_busy_d;
  logic [AES_LATENCY-1:0]     dl_vld_q;
  logic [ID_WIDTH-1:0]        dl_id_q [AES_LATENCY];

  logic [NUM_REQ-1:0]         gnt;
  logic                       xfer;
  logic [ID_WIDTH-1:0]        xfer_id;

  aes_sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ID_WIDTH)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_q),
    .gnt_o (gnt)
  );

  // Grant gating and zero-latency issue mux into the core
  always_comb begin
    req_ready = '0;
    aes_state = '0;
    xfer_id   = '0;
    if (state_q == SCHED_RUN && !key_wr) begin
      req_ready = gnt;
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (req_ready[j]) begin
        aes_state = req_data[AES_BLOCK_W*j +: AES_BLOCK_W];
        xfer_id   = ID_WIDTH'(j);
      end
    end
    xfer = |req_ready;
  end

  // Key-change sequencing and bookkeeping
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_pend_d  = key_wr ? key_in : key_pend_q;
    rr_d        = xfer ? xfer_id : rr_q;
    in_flight_d = in_flight_q + IN_FLIGHT_W'(xfer) - IN_FLIGHT_W'(dl_vld_q[AES_LATENCY-1]);
    case (state_q)
      SCHED_RUN: begin
        if (key_wr) state_d = SCHED_DRAIN;
      end
      SCHED_DRAIN: begin
        if (in_flight_q == '0) state_d = SCHED_LOAD;
      end
      SCHED_LOAD: begin
        // Forward a write landing in this very cycle so it is not lost
        key_d   = key_pend_d;
        state_d = SCHED_RUN;
      end
      default: state_d = SCHED_RUN;
    endcase
    key_busy_d = (state_d != SCHED_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCHED_RUN;
      key_q       <= '0;
      key_pend_q  <= '0;
      rr_q        <= ID_WIDTH'(NUM_REQ - 1);
      in_flight_q <= '0;
      key_busy_q  <= 1'b0;
      dl_vld_q    <= '0;
      for (int unsigned i = 0; i < AES_LATENCY; i++) dl_id_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_pend_q  <= key_pend_d;
      rr_q        <= rr_d;
      in_flight_q <= in_flight_d;
      key_busy_q  <= key_busy_d;
      // Delay line matched to the core latency, shifts every cycle
      for (int unsigned i = AES_LATENCY - 1; i > 0; i--) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_id_q[i]  <= dl_id_q[i-1];
      end
      dl_vld_q[0] <= xfer;
      dl_id_q[0]  <= xfer_id;
    end
  end

  assign aes_key   = {4{key_q}};
  assign rsp_valid = dl_vld_q[AES_LATENCY-1];
  assign rsp_id    = dl_id_q[AES_LATENCY-1];
  assign rsp_data  = aes_out;
  assign in_flight = in_flight_q;
  assign key_busy  = key_busy_q;

endmodule

// File: tb/tb_aes_sched.sv
// Bench for aes_sched: a behavioural AES-128 core model feeds the DUT, and a
// scoreboard predicts grants, tagged ciphertexts, occupancy and key-change timing.
module tb_aes_sched;

  localparam int unsigned N   = 2;
  localparam int unsigned L   = 21;
  localparam int unsigned IDW = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N*128-1:0] req_data;
  logic [N-1:0]     req_ready;
  logic             key_wr;
  logic [31:0]      key_in;
  logic [127:0]     aes_state, aes_key, aes_out;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [127:0]     rsp_data;
  logic [4:0]       in_flight;
  logic             key_busy;

  always #5 clk = ~clk;

  aes_sched #(.NUM_REQ(N), .AES_LATENCY(L), .ID_WIDTH(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .key_wr    (key_wr),
    .key_in    (key_in),
    .aes_state (aes_state),
    .aes_key   (aes_key),
    .aes_out   (aes_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .in_flight (in_flight),
    .key_busy  (key_busy)
  );

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    logic [7:0]  a0, a1, a2, a3;
    logic [127:0] ct;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = s[r+4*c] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction

  // Free-running pipelined core stand-in
  logic [127:0] core_pipe [L];
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
    core_pipe[0] <= aes128(aes_state, aes_key);
  end
  assign aes_out = core_pipe[L-1];

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    int             due;
    logic [IDW-1:0] id;
    logic [127:0]   data;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          rr_m;
  logic        busy_m, loading_m;
  logic [31:0] key_last, key_active;

  function automatic logic [127:0] rand_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    logic [N-1:0] exp_rdy;
    logic [127:0] exp_state;
    logic         exp_rv;
    int           g, n_in;
    exp_t         e;
    #1;
    if (reset) begin
      q.delete();
      busy_m = 1'b0; loading_m = 1'b0;
      key_last = '0; key_active = '0;
      rr_m = N - 1;
    end else begin
      n_in = q.size();
      g = -1;
      if (!busy_m && !key_wr)
        for (int k = 1; k <= N; k++)
          if (g < 0 && req_valid[(rr_m + k) % N]) g = (rr_m + k) % N;
      exp_rdy   = '0;
      exp_state = '0;
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        exp_state  = req_data[128*g +: 128];
      end
      n_vec++;
      assert (req_ready === exp_rdy) else begin
        n_err++; $error("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
      end
      n_vec++;
      assert (aes_state === exp_state) else begin
        n_err++; $error("FAIL aes_state cyc=%0d got=%h exp=%h", cyc, aes_state, exp_state);
      end
      n_vec++;
      assert (key_busy === busy_m) else begin
        n_err++; $error("FAIL key_busy cyc=%0d got=%b exp=%b", cyc, key_busy, busy_m);
      end
      n_vec++;
      assert (in_flight === 5'(n_in)) else begin
        n_err++; $error("FAIL in_flight cyc=%0d got=%0d exp=%0d", cyc, in_flight, n_in);
      end
      exp_rv = (n_in > 0) && (q[0].due == cyc);
      n_vec++;
      assert (rsp_valid === exp_rv) else begin
        n_err++; $error("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv);
      end
      if (exp_rv) begin
        e = q.pop_front();
        n_vec++;
        assert (rsp_id === e.id) else begin
          n_err++; $error("FAIL rsp_id cyc=%0d got=%0d exp=%0d", cyc, rsp_id, e.id);
        end
        n_vec++;
        assert (rsp_data === e.data) else begin
          n_err++; $error("FAIL rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, e.data);
        end
      end else begin
        n_vec++;
        assert (rsp_id === '0) else begin
          n_err++; $error("FAIL rsp_id_idle cyc=%0d got=%0d exp=0", cyc, rsp_id);
        end
      end
      if (g >= 0) begin
        e.due  = cyc + L;
        e.id   = IDW'(g);
        e.data = aes128(req_data[128*g +: 128], {4{key_active}});
        q.push_back(e);
        rr_m = g;
      end
      // Key change: blocked from the write, drained, then one load cycle
      if (key_wr) key_last = key_in;
      if (!busy_m) begin
        if (key_wr) busy_m = 1'b1;
      end else if (loading_m) begin
        busy_m = 1'b0; loading_m = 1'b0; key_active = key_last;
      end else if (n_in == 0) begin
        loading_m = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (key_busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    n_vec++;
    assert (key_busy === 1'b0) else begin
      n_err++; $error("FAIL busy_timeout cyc=%0d got=%b exp=0", cyc, key_busy);
    end
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    key_wr    = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    init_sbox();
    req_valid = '0; req_data = '0; key_wr = 1'b0; key_in = '0; reset = 1'b1;
    step(); step();
    reset = 1'b0;
    idle(2);

    // Known block under the all-zero key
    key_wr = 1'b1; key_in = 32'h0000_0000; step(); key_wr = 1'b0;
    wait_busy();
    req_data[127:0] = 128'h00112233445566778899aabbccddeeff;
    req_valid = 2'b01; step();
    idle(L + 3);

    // Both requesters saturating: strict rotation
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      req_data = {rand_blk(), rand_blk()};
      step();
    end
    idle(L + 2);

    // Key change with five blocks in flight, requesters still asking
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      req_data = {rand_blk(), rand_blk()};
      step();
    end
    key_wr = 1'b1; key_in = 32'h0123_4567; step(); key_wr = 1'b0;
    wait_busy();
    req_valid = 2'b01; req_data = {rand_blk(), rand_blk()}; step();
    idle(L + 2);

    // Two writes before the load: last one wins
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      req_data = {rand_blk(), rand_blk()};
      step();
    end
    req_valid = '0;
    key_wr = 1'b1; key_in = 32'hAAAA_AAAA; step();
    key_in = 32'h5555_5555; step();
    key_wr = 1'b0;
    wait_busy();
    req_valid = 2'b10; req_data = {rand_blk(), rand_blk()}; step();
    idle(L + 2);

    // Reset with blocks in flight
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      req_data = {rand_blk(), rand_blk()};
      step();
    end
    req_valid = '0; reset = 1'b1; step(); reset = 1'b0;
    idle(L + 2);
    req_valid = 2'b10; req_data = {rand_blk(), rand_blk()}; step();
    idle(L + 2);

    // Single requester toggling every cycle
    for (int i = 0; i < 20; i++) begin
      req_valid = (i % 2 == 0) ? 2'b01 : 2'b00;
      req_data  = {rand_blk(), rand_blk()};
      step();
    end
    idle(L + 2);

    // Random traffic with occasional key writes
    for (int i = 0; i < 300; i++) begin
      req_valid = N'($urandom_range(0, 3));
      req_data  = {rand_blk(), rand_blk()};
      key_wr    = ($urandom_range(0, 39) == 0);
      key_in    = $urandom();
      step();
    end
    req_valid = '0; key_wr = 1'b0;
    wait_busy();
    idle(L + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
